divider_iter: RTL and testbench

- Parametrised, handshaked, multi-cycle unsigned integer divider: M-bit dividend / N-bit divisor -> M-bit quotient, N-bit remainder.
- Successor to the fixed-width pipelined divider. Adds:
  - a remainder output
  - valid/ready flow control
  - divide-by-zero detection
  - selectable radix (K quotient bits per cycle)
- Sits between datapath blocks that need occasional division without paying for a full pipeline.

---
 rtl/div_pkg.sv | 10 +
 rtl/div_radix2_step.sv | 20 ++
 rtl/divider_iter.sv | 139 +++++++++++++
 tb/tb_divider_iter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: FSM state type and elaboration helpers shared by divider_iter
package div_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, FIX} state_t;
  function automatic bit k_legal(input int k, input int m);
    return (k == 1 || k == 2 || k == 4) && (m % k == 0);
  endfunction
  function automatic int cnt_w(input int iter);
    return iter > 1 ? $clog2(iter) : 1;
  endfunction
endpackage

// File: rtl/div_radix2_step.sv
// div_radix2_step: one combinational restoring radix-2 division step
//   i_rem  partial remainder (always < i_div)
//   i_div  divisor
//   i_bit  next dividend bit, MSB first
//   o_rem  new partial remainder, o_q quotient bit
module div_radix2_step #(
  parameter int N = 14
) (
  input  logic [N-1:0] i_rem,
  input  logic [N-1:0] i_div,
  input  logic         i_bit,
  output logic [N-1:0] o_rem,
  output logic         o_q
);
  logic [N:0] w_sh;
  assign w_sh = {i_rem, i_bit};
  assign o_q = w_sh >= {1'b0, i_div};
  // when the subtract happens the result is below i_div, so N-bit wraparound is exact
  assign o_rem = o_q ? w_sh[N-1:0] - i_div : w_sh[N-1:0];
endmodule

// File: rtl/divider_iter.sv
// divider_iter: handshaked iterative M/N-bit divider retiring K quotient bits per cycle
//   in_valid/in_ready/dividend/divisor   operand handshake, sampled on accept
//   out_valid/out_ready/quotient/remainder/div_by_zero   result handshake, held until taken
//   DIV_SIGNED_EN: two's complement operands, truncating division via an extra FIX cycle
module divider_iter
  import div_pkg::*;
#(
  parameter int M = 26,
  parameter int N = 14,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int ITER = M / K;
  localparam int CW = cnt_w(ITER);
  if (!k_legal(K, M) || M < N || N < 2) begin : g_bad_param
    $error("divider_iter: K must be 1, 2 or 4 dividing M, and M >= N >= 2");
  end
  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [M-1:0]   r_quo;
  logic [N-1:0]   r_rem;
  logic [N-1:0]   r_dsr;
  logic           r_in_ready;
  logic           r_out_valid;
  logic           r_dbz;
  logic [M-1:0]   w_a_mag;
  logic [N-1:0]   w_b_mag;
  logic [M-1:0]   w_quo_nx;
  logic [K-1:0]   w_qb;
  logic [N-1:0]   w_rem [K+1];
`ifdef DIV_SIGNED_EN
  logic           r_neg_q;
  logic           r_neg_r;
  assign w_a_mag = dividend[M-1] ? -dividend : dividend;
  assign w_b_mag = divisor[N-1] ? -divisor : divisor;
`else
  assign w_a_mag = dividend;
  assign w_b_mag = divisor;
`endif
  // r_quo doubles as the dividend shift register: dividend bits leave at the top, quotient bits enter at the bottom
  assign w_rem[0] = r_rem;
  for (genvar i = 0; i < K; i++) begin : g_step
    div_radix2_step #(.N(N)) u_step (
      .i_rem(w_rem[i]),
      .i_div(r_dsr),
      .i_bit(r_quo[M-1-i]),
      .o_rem(w_rem[i+1]),
      .o_q  (w_qb[K-1-i])
    );
  end
  always_comb begin
    w_quo_nx = r_quo << K;
    w_quo_nx[K-1:0] = w_qb;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dsr       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_in_ready <= 1'b0;
`ifdef DIV_SIGNED_EN
          r_neg_q <= dividend[M-1] ^ divisor[N-1];
          r_neg_r <= dividend[M-1];
`endif
          if (divisor == '0) begin
            r_quo   <= '1;
            r_rem   <= dividend[N-1:0];
            r_dbz   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_quo   <= w_a_mag;
            r_rem   <= '0;
            r_dsr   <= w_b_mag;
            r_dbz   <= 1'b0;
            r_cnt   <= CW'(ITER - 1);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_quo <= w_quo_nx;
          r_rem <= w_rem[K];
          if (r_cnt == '0) begin
`ifdef DIV_SIGNED_EN
            r_state <= FIX;
`else
            r_state     <= DONE;
            r_out_valid <= 1'b1;
`endif
          end else
            r_cnt <= r_cnt - 1'b1;
        end
`ifdef DIV_SIGNED_EN
        FIX: begin
          r_quo       <= r_neg_q ? -r_quo : r_quo;
          r_rem       <= r_neg_r ? -r_rem : r_rem;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
`endif
        // divide-by-zero arrives here with out_valid low and raises it one edge later
        DONE: if (!r_out_valid)
          r_out_valid <= 1'b1;
        else if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_divider_iter.sv
// tb_divider_iter: scoreboard bench for divider_iter, K=1 and K=2 instances at M=16 N=8
module tb_divider_iter;
`ifdef DIV_SIGNED_EN
  localparam int XL = 1;
  localparam bit SG = 1'b1;
`else
  localparam int XL = 0;
  localparam bit SG = 1'b0;
`endif
  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] iv = '0, ir, ov, ordy = 2'b11, dz, pv = '0;
  logic [1:0][15:0] dvd = '0, quo;
  logic [1:0][7:0] dsr = '0, rem;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  divider_iter #(.M(16), .N(8), .K(1)) u_k1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .dividend(dvd[0]), .divisor(dsr[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .quotient(quo[0]), .remainder(rem[0]), .div_by_zero(dz[0]));
  divider_iter #(.M(16), .N(8), .K(2)) u_k2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .dividend(dvd[1]), .divisor(dsr[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .quotient(quo[1]), .remainder(rem[1]), .div_by_zero(dz[1]));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      if (ov[u] && !pv[u]) begin
        if ((u == 0 && sb0.size() == 0) || (u == 1 && sb1.size() == 0))
          chk($sformatf("dut%0d/unexpected_valid", u), 1, 0);
        else begin
          if (u == 0) e = sb0.pop_front();
          else e = sb1.pop_front();
          chk({e.nm, "/q"}, quo[u], e.q);
          chk({e.nm, "/r"}, rem[u], e.r);
          chk({e.nm, "/dbz"}, dz[u], e.z);
          chk({e.nm, "/latency"}, cyc - e.acc, e.lat);
        end
      end
      pv[u] <= ov[u];
    end
  end
  task automatic send(input int u, input logic [15:0] a, input logic [7:0] b, input logic [15:0] q,
                      input logic [7:0] r, input logic z, input int lat, input string nm);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!ir[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir[u]) begin
      chk({nm, "/accept_timeout"}, ir[u], 1);
      return;
    end
    dvd[u] = a;
    dsr[u] = b;
    iv[u] = 1'b1;
    @(posedge clk);
    #1;
    iv[u] = 1'b0;
    dvd[u] = ~a;
    dsr[u] = ~b;
    e.q = q; e.r = r; e.z = z; e.lat = lat; e.acc = cyc; e.nm = nm;
    if (u == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask
  task automatic drain();
    int n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain/pending", sb0.size() + sb1.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset/out_valid", ov, 2'b00);
    chk("reset/quotient", quo[0], 0);
    chk("reset/remainder", rem[0], 0);
    chk("reset/dbz", dz[0], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset/in_ready", ir, 2'b11);
    send(0, 16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 16 + XL, "100/7");
    send(1, 16'hFFFF, 8'hFF, SG ? 16'd1 : 16'd257, 8'd0, 1'b0, 8 + XL, "ffff/ff_k2");
    send(0, 16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1, "div0");
    send(0, 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 16 + XL, "5/9");
    send(1, 16'd200, 8'd9, 16'd22, 8'd2, 1'b0, 8 + XL, "200/9_k2");
    send(0, 16'hFFFF, 8'd1, 16'hFFFF, 8'd0, 1'b0, 16 + XL, "ffff/1");
    send(0, 16'hFF9C, 8'd7, SG ? 16'hFFF2 : 16'h2484, SG ? 8'hFE : 8'h00, 1'b0, 16 + XL, "ff9c/7");
    send(0, 16'h8000, 8'hFF, SG ? 16'h8000 : 16'h0080, SG ? 8'h00 : 8'h80, 1'b0, 16 + XL, "8000/ff");
    send(0, 16'h00FF, 8'hFE, SG ? 16'hFF81 : 16'h0001, 8'h01, 1'b0, 16 + XL, "ff/fe");
    send(0, 16'h8001, 8'h00, 16'hFFFF, 8'h01, 1'b1, 1, "div0_8001");
    drain();
    ordy[0] = 1'b0;
    send(0, 16'd1000, 8'd13, 16'd76, 8'd12, 1'b0, 16 + XL, "bp");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov[0] && n < 100);
    chk("bp/valid_seen", ov[0], 1);
    iv[0] = 1'b1;
    dvd[0] = 16'h5555;
    dsr[0] = 8'h03;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp/hold_valid", ov[0], 1);
      chk("bp/hold_in_ready", ir[0], 0);
      chk("bp/hold_q", quo[0], 76);
      chk("bp/hold_r", rem[0], 12);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp/after_valid", ov[0], 0);
    chk("bp/after_in_ready", ir[0], 1);
    drain();
    send(0, 16'd300, 8'd7, 16'd42, 8'd6, 1'b0, 16 + XL, "abort");
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    sb0.delete();
    @(negedge clk);
    chk("abort/valid_in_reset", ov[0], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort/in_ready", ir[0], 1);
    chk("abort/valid", ov[0], 0);
    chk("abort/quotient", quo[0], 0);
    repeat (20) @(negedge clk);
    send(0, 16'd200, 8'd9, 16'd22, 8'd2, 1'b0, 16 + XL, "200/9_after_abort");
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
